agc_window_ctrl: RTL and testbench
==================================

Name: agc_window_ctrl

Overview:
Parametrised successor to the fixed 4-step relay AGC. It measures the peak-to-peak amplitude of the ADC stream over a sample window and steps an N-level relay/PGA gain code. Step-down is fast on a clipped sample; step-up is slow and confirmed over several windows, with hysteresis. It adds a post-switch settle period, manual override, freeze and amplitude reporting. It sits between the ADC capture front end and the relay drivers, in the single system clock domain.

Parameters:
DATA_W, 12, ADC sample width (unsigned offset-binary)
STEPS, 4, number of gain levels; code 0 = lowest gain
GAIN_W, 2, gain code width; must satisfy 2**GAIN_W >= STEPS
WIN_LEN, 256, valid samples per measurement window
SETTLE_CYC, 1000, clk cycles ignored after any gain change
HI_TH, 3000, p2p above this at window end -> step down
LO_TH, 1024, p2p below this -> step-up candidate
HYST, 128, up threshold becomes LO_TH-HYST after a down step
CLIP_HI, 4080, sample >= this is clipped
CLIP_LO, 15, sample <= this is clipped
UP_CONFIRM, 2, consecutive qualifying windows before step up

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
sample_valid  in  1  one-cycle strobe, sample_data valid
sample_data  in  DATA_W  ADC sample
manual_en  in  1  level; 1 = manual gain mode
manual_gain  in  GAIN_W  requested gain in manual mode
freeze  in  1  level; hold gain, keep measuring
gain_code  out  GAIN_W  relay/PGA gain code, registered
gain_change  out  1  one-cycle pulse on every gain_code change
stable  out  1  gain settled and last window caused no change
over_range  out  1  clip seen in current/last window
amp  out  DATA_W  p2p (max-min) of last completed window
amp_valid  out  1  one-cycle pulse when amp updates

Behaviour:
- Reset (rst_n=0 at clk edge): gain_code=0, gain_change=0, stable=0, over_range=0, amp=0, amp_valid=0, up_cnt=0, last_dir=up, state=SETTLE with settle counter=SETTLE_CYC. A reset in any state or mid-window takes priority over all events.
- States: SETTLE, MEASURE, HOLD.
- SETTLE: counts clk cycles, not samples. Ignores sample_valid. At count 0 -> MEASURE, or HOLD if manual_en=1. Window max/min are cleared and the sample counter is zeroed on exit.
- MEASURE: on each sample_valid, update running max/min and increment the counter. The sample that completes WIN_LEN closes the window.
- Window close, next cycle: amp=max-min, amp_valid=1, then the decision in priority order:
  1. p2p>HI_TH and gain>0 -> gain-1, last_dir=down.
  2. p2p<up_th and gain<STEPS-1 -> up_cnt+1; when up_cnt reaches UP_CONFIRM: gain+1, last_dir=up, up_cnt=0. up_th=LO_TH-HYST if last_dir=down, else LO_TH.
  3. Otherwise up_cnt=0 and stable=1.
- Fast attack: a clipped sample in MEASURE sets over_range=1. If gain>0 and freeze=0: gain-1 on the next cycle, window aborted, up_cnt=0, last_dir=down. At gain 0 only over_range is set and the window continues.
- over_range clears at the next window close that had no clipped sample.
- Any gain change: gain_change=1 for one cycle, stable=0, enter SETTLE with counter=SETTLE_CYC.
- freeze=1: measurement and amp reporting continue; gain changes and up_cnt increments are suppressed; stable is unaffected.
- Manual mode: rising manual_en or manual_gain change while manual_en=1 loads min(manual_gain, STEPS-1) next cycle. If the value differs from current gain -> gain_change pulse, then SETTLE, then HOLD. HOLD: stable=1, samples ignored.
- manual_en falling -> MEASURE with a fresh window, up_cnt=0, stable=0 until the first window close with no change.
- Simultaneous window close and clip on the same sample: the clip path wins.
- Boundaries: gain never wraps below 0 or above STEPS-1. Settle and window counters are sized for SETTLE_CYC and WIN_LEN inclusive. max-min uses DATA_W unsigned arithmetic and never goes negative.

Test Plan:
(Bench params: WIN_LEN=16, SETTLE_CYC=20, others default.)
1. Release reset, feed 16 samples spanning 1000..3000 -> gain_code=0; 20 clk later first window closes, amp=2000, amp_valid pulse, stable=1, no gain_change.
2. Two windows of p2p=500 at gain 0 -> first window: no change (up_cnt=1); second window: gain_code=1, gain_change pulse, stable=0, samples ignored for 20 clk.
3. At gain 2 inject sample 4090 mid-window -> next cycle gain_code=1, over_range=1, window aborted; a following clean window (p2p 2000) clears over_range.
4. After the step down in case 3, two windows p2p=950 -> no step (950 > 896). Two windows p2p=850 -> gain_code=2.
5. manual_en=1, manual_gain=3 -> gain_code=3 next cycle, HOLD after 20 clk, stable=1; p2p=4000 windows cause no change. Separate instance with STEPS=3 and manual_gain=3 -> gain_code=2.
6. freeze=1 with p2p=500 windows -> amp updates, gain constant. Then rst_n=0 mid-SETTLE -> all outputs at reset values on the next clk edge.

Source files
------------

// File: rtl/agc_window_ctrl.sv
// Windowed peak-to-peak AGC: steps an N-level relay/PGA gain code from ADC amplitude,
// with fast clip attack, confirmed slow step-up with hysteresis, settle, manual and freeze.
module agc_window_ctrl #(
    parameter int DATA_W     = 12,
    parameter int STEPS      = 4,
    parameter int GAIN_W     = 2,
    parameter int WIN_LEN    = 256,
    parameter int SETTLE_CYC = 1000,
    parameter int HI_TH      = 3000,
    parameter int LO_TH      = 1024,
    parameter int HYST       = 128,
    parameter int CLIP_HI    = 4080,
    parameter int CLIP_LO    = 15,
    parameter int UP_CONFIRM = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              manual_en,
    input  logic [GAIN_W-1:0] manual_gain,
    input  logic              freeze,
    output logic [GAIN_W-1:0] gain_code,
    output logic              gain_change,
    output logic              stable,
    output logic              over_range,
    output logic [DATA_W-1:0] amp,
    output logic              amp_valid
);
    localparam int SC_W = $clog2(SETTLE_CYC + 1);
    localparam int WC_W = $clog2(WIN_LEN + 1);
    localparam int UC_W = $clog2(UP_CONFIRM + 1);

    localparam logic [1:0] ST_SETTLE  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    localparam logic [GAIN_W-1:0] GAIN_MAX = GAIN_W'(STEPS - 1);

    logic [1:0]        state_reg;
    logic [SC_W-1:0]   settle_cnt_reg;
    logic [WC_W-1:0]   samp_cnt_reg;
    logic [DATA_W-1:0] max_reg, min_reg;
    logic              win_clip_reg;
    logic [UC_W-1:0]   up_cnt_reg;
    logic              last_down_reg;
    logic [GAIN_W-1:0] gain_reg;
    logic              gain_change_reg, stable_reg, over_range_reg, amp_valid_reg;
    logic [DATA_W-1:0] amp_reg;
    logic              manual_en_d_reg;
    logic [GAIN_W-1:0] manual_gain_d_reg;

    logic              sample_clip, win_done, manual_evt, manual_fall;
    logic [DATA_W-1:0] max_next, min_next, p2p, up_th;
    logic [GAIN_W-1:0] manual_target;

    assign sample_clip   = (sample_data >= DATA_W'(CLIP_HI)) || (sample_data <= DATA_W'(CLIP_LO));
    assign max_next      = (sample_data > max_reg) ? sample_data : max_reg;
    assign min_next      = (sample_data < min_reg) ? sample_data : min_reg;
    // Includes the closing sample, so the decision lands the cycle after it arrives
    assign p2p           = max_next - min_next;
    assign up_th         = last_down_reg ? DATA_W'(LO_TH - HYST) : DATA_W'(LO_TH);
    assign win_done      = (samp_cnt_reg == WC_W'(WIN_LEN - 1));
    assign manual_target = (manual_gain > GAIN_MAX) ? GAIN_MAX : manual_gain;
    assign manual_evt    = manual_en && (!manual_en_d_reg || (manual_gain != manual_gain_d_reg));
    assign manual_fall   = !manual_en && manual_en_d_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg         <= ST_SETTLE;
            settle_cnt_reg    <= SC_W'(SETTLE_CYC);
            samp_cnt_reg      <= '0;
            max_reg           <= '0;
            min_reg           <= '1;
            win_clip_reg      <= 1'b0;
            up_cnt_reg        <= '0;
            last_down_reg     <= 1'b0;
            gain_reg          <= '0;
            gain_change_reg   <= 1'b0;
            stable_reg        <= 1'b0;
            over_range_reg    <= 1'b0;
            amp_reg           <= '0;
            amp_valid_reg     <= 1'b0;
            manual_en_d_reg   <= 1'b0;
            manual_gain_d_reg <= '0;
        end else begin
            gain_change_reg   <= 1'b0;
            amp_valid_reg     <= 1'b0;
            manual_en_d_reg   <= manual_en;
            manual_gain_d_reg <= manual_gain;
            if (manual_evt) begin
                samp_cnt_reg <= '0;
                max_reg      <= '0;
                min_reg      <= '1;
                win_clip_reg <= 1'b0;
                if (manual_target != gain_reg) begin
                    gain_reg        <= manual_target;
                    gain_change_reg <= 1'b1;
                    stable_reg      <= 1'b0;
                    state_reg       <= ST_SETTLE;
                    settle_cnt_reg  <= SC_W'(SETTLE_CYC);
                end else if (state_reg != ST_SETTLE) begin
                    state_reg  <= ST_HOLD;
                    stable_reg <= 1'b1;
                end
            end else if (manual_fall) begin
                state_reg    <= ST_MEASURE;
                samp_cnt_reg <= '0;
                max_reg      <= '0;
                min_reg      <= '1;
                win_clip_reg <= 1'b0;
                up_cnt_reg   <= '0;
                stable_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    ST_SETTLE: begin
                        samp_cnt_reg <= '0;
                        max_reg      <= '0;
                        min_reg      <= '1;
                        win_clip_reg <= 1'b0;
                        if (settle_cnt_reg == '0) begin
                            state_reg <= manual_en ? ST_HOLD : ST_MEASURE;
                            if (manual_en) stable_reg <= 1'b1;
                        end else begin
                            settle_cnt_reg <= settle_cnt_reg - 1'b1;
                        end
                    end
                    ST_MEASURE: begin
                        if (sample_valid) begin
                            if (sample_clip && (gain_reg != '0) && !freeze) begin
                                // Fast attack pre-empts any window close on this same sample
                                over_range_reg  <= 1'b1;
                                gain_reg        <= gain_reg - 1'b1;
                                gain_change_reg <= 1'b1;
                                up_cnt_reg      <= '0;
                                last_down_reg   <= 1'b1;
                                stable_reg      <= 1'b0;
                                state_reg       <= ST_SETTLE;
                                settle_cnt_reg  <= SC_W'(SETTLE_CYC);
                            end else if (win_done) begin
                                amp_reg        <= p2p;
                                amp_valid_reg  <= 1'b1;
                                over_range_reg <= win_clip_reg | sample_clip;
                                samp_cnt_reg   <= '0;
                                max_reg        <= '0;
                                min_reg        <= '1;
                                win_clip_reg   <= 1'b0;
                                if ((p2p > DATA_W'(HI_TH)) && (gain_reg != '0)) begin
                                    if (!freeze) begin
                                        gain_reg        <= gain_reg - 1'b1;
                                        gain_change_reg <= 1'b1;
                                        up_cnt_reg      <= '0;
                                        last_down_reg   <= 1'b1;
                                        stable_reg      <= 1'b0;
                                        state_reg       <= ST_SETTLE;
                                        settle_cnt_reg  <= SC_W'(SETTLE_CYC);
                                    end
                                end else if ((p2p < up_th) && (gain_reg < GAIN_MAX)) begin
                                    if (!freeze) begin
                                        if (up_cnt_reg == UC_W'(UP_CONFIRM - 1)) begin
                                            gain_reg        <= gain_reg + 1'b1;
                                            gain_change_reg <= 1'b1;
                                            up_cnt_reg      <= '0;
                                            last_down_reg   <= 1'b0;
                                            stable_reg      <= 1'b0;
                                            state_reg       <= ST_SETTLE;
                                            settle_cnt_reg  <= SC_W'(SETTLE_CYC);
                                        end else begin
                                            up_cnt_reg <= up_cnt_reg + 1'b1;
                                            stable_reg <= 1'b1;
                                        end
                                    end
                                end else begin
                                    up_cnt_reg <= '0;
                                    if (!freeze) stable_reg <= 1'b1;
                                end
                            end else begin
                                if (sample_clip) begin
                                    over_range_reg <= 1'b1;
                                    win_clip_reg   <= 1'b1;
                                end
                                max_reg      <= max_next;
                                min_reg      <= min_next;
                                samp_cnt_reg <= samp_cnt_reg + 1'b1;
                            end
                        end
                    end
                    ST_HOLD: begin
                        samp_cnt_reg <= '0;
                        max_reg      <= '0;
                        min_reg      <= '1;
                        win_clip_reg <= 1'b0;
                        stable_reg   <= 1'b1;
                    end
                    default: state_reg <= ST_SETTLE;
                endcase
            end
        end
    end

    assign gain_code   = gain_reg;
    assign gain_change = gain_change_reg;
    assign stable      = stable_reg;
    assign over_range  = over_range_reg;
    assign amp         = amp_reg;
    assign amp_valid   = amp_valid_reg;
endmodule

// File: tb/tb_agc_window_ctrl.sv
// Directed, table-driven bench for agc_window_ctrl (WIN_LEN=16, SETTLE_CYC=20).
module tb_agc_window_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [11:0] sample_data;
    logic        manual_en;
    logic [1:0]  manual_gain;
    logic        freeze;
    logic [1:0]  gain_code;
    logic        gain_change, stable, over_range, amp_valid;
    logic [11:0] amp;

    logic        sample_valid2, manual_en2, freeze2;
    logic [11:0] sample_data2;
    logic [1:0]  manual_gain2, gain_code2;
    logic        gain_change2, stable2, over_range2, amp_valid2;
    logic [11:0] amp2;

    int tests = 0;
    int fails = 0;
    int gc_cnt = 0;
    int av_cnt = 0;

    always #5 clk = ~clk;

    agc_window_ctrl #(.WIN_LEN(16), .SETTLE_CYC(20)) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
        .manual_en(manual_en), .manual_gain(manual_gain), .freeze(freeze),
        .gain_code(gain_code), .gain_change(gain_change), .stable(stable),
        .over_range(over_range), .amp(amp), .amp_valid(amp_valid)
    );

    agc_window_ctrl #(.STEPS(3), .WIN_LEN(16), .SETTLE_CYC(20)) dut3 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid2), .sample_data(sample_data2),
        .manual_en(manual_en2), .manual_gain(manual_gain2), .freeze(freeze2),
        .gain_code(gain_code2), .gain_change(gain_change2), .stable(stable2),
        .over_range(over_range2), .amp(amp2), .amp_valid(amp_valid2)
    );

    always @(negedge clk) begin
        if (gain_change === 1'b1) gc_cnt++;
        if (amp_valid === 1'b1) av_cnt++;
    end

    typedef struct {
        int lo; int hi; int clip_at; bit frz;
        int gain; int amp; int ap; int gp; bit stab; bit ovr;
    } vec_t;
    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 16 samples: lo, hi, then midpoints; optional clipped sample at index clip_at
    task automatic send_window(input int lo, input int hi, input int clip_at);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            if (i == clip_at)  sample_data = 12'd4090;
            else if (i == 0)   sample_data = 12'(lo);
            else if (i == 1)   sample_data = 12'(hi);
            else               sample_data = 12'((lo + hi) / 2);
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        int gc0, av0;
        vecs[0]  = '{1000, 3000, -1, 1'b0, 0, 2000, 1, 0, 1'b1, 1'b0};
        vecs[1]  = '{1000, 3000,  8, 1'b0, 0, 3090, 1, 0, 1'b1, 1'b1};
        vecs[2]  = '{1000, 3000, -1, 1'b0, 0, 2000, 1, 0, 1'b1, 1'b0};
        vecs[3]  = '{1000, 1500, -1, 1'b0, 0,  500, 1, 0, 1'b1, 1'b0};
        vecs[4]  = '{1000, 1500, -1, 1'b0, 1,  500, 1, 1, 1'b0, 1'b0};
        vecs[5]  = '{1000, 1500, -1, 1'b0, 1,  500, 1, 0, 1'b1, 1'b0};
        vecs[6]  = '{1000, 1500, -1, 1'b0, 2,  500, 1, 1, 1'b0, 1'b0};
        vecs[7]  = '{1000, 3000,  8, 1'b0, 1,  500, 0, 1, 1'b0, 1'b1};
        vecs[8]  = '{1000, 3000, -1, 1'b0, 1, 2000, 1, 0, 1'b1, 1'b0};
        vecs[9]  = '{1000, 1950, -1, 1'b0, 1,  950, 1, 0, 1'b1, 1'b0};
        vecs[10] = '{1000, 1950, -1, 1'b0, 1,  950, 1, 0, 1'b1, 1'b0};
        vecs[11] = '{1000, 1850, -1, 1'b0, 1,  850, 1, 0, 1'b1, 1'b0};
        vecs[12] = '{1000, 1850, -1, 1'b0, 2,  850, 1, 1, 1'b0, 1'b0};
        vecs[13] = '{1000, 1500, -1, 1'b1, 2,  500, 1, 0, 1'b0, 1'b0};
        vecs[14] = '{1000, 1500, -1, 1'b1, 2,  500, 1, 0, 1'b0, 1'b0};
        vecs[15] = '{1000, 1500, -1, 1'b0, 2,  500, 1, 0, 1'b1, 1'b0};
        vecs[16] = '{1000, 3000,  8, 1'b1, 2, 3090, 1, 0, 1'b1, 1'b1};
        vecs[17] = '{1000, 3500, -1, 1'b0, 2, 2500, 1, 0, 1'b1, 1'b0};
        vecs[18] = '{ 500, 3600, -1, 1'b0, 1, 3100, 1, 1, 1'b0, 1'b0};

        rst_n = 1'b0; sample_valid = 1'b0; sample_data = '0;
        manual_en = 1'b0; manual_gain = '0; freeze = 1'b0;
        sample_valid2 = 1'b0; sample_data2 = '0; manual_en2 = 1'b0; manual_gain2 = '0; freeze2 = 1'b0;
        idle(3);
        check("reset_gain", gain_code, 0);
        check("reset_stable", stable, 0);
        check("reset_amp", amp, 0);
        check("reset_amp_valid", amp_valid, 0);
        rst_n = 1'b1;
        idle(25);

        for (int v = 0; v < 19; v++) begin
            gc0 = gc_cnt; av0 = av_cnt;
            freeze = vecs[v].frz;
            send_window(vecs[v].lo, vecs[v].hi, vecs[v].clip_at);
            idle(25);
            freeze = 1'b0;
            $display("[TB] vec %0d lo=%0d hi=%0d clip=%0d frz=%0d -> gain=%0d amp=%0d stable=%0d over=%0d",
                     v, vecs[v].lo, vecs[v].hi, vecs[v].clip_at, vecs[v].frz, gain_code, amp, stable, over_range);
            check($sformatf("v%0d_gain", v), gain_code, vecs[v].gain);
            check($sformatf("v%0d_amp", v), amp, vecs[v].amp);
            check($sformatf("v%0d_amp_pulses", v), av_cnt - av0, vecs[v].ap);
            check($sformatf("v%0d_gc_pulses", v), gc_cnt - gc0, vecs[v].gp);
            check($sformatf("v%0d_stable", v), stable, vecs[v].stab);
            check($sformatf("v%0d_over", v), over_range, vecs[v].ovr);
        end

        // Manual load: one-cycle latency, samples ignored while settling, then HOLD
        manual_en = 1'b1; manual_gain = 2'd3;
        @(negedge clk);
        $display("[TB] manual_en=1 gain=3 -> gain=%0d change=%0d", gain_code, gain_change);
        check("man_gain", gain_code, 3);
        check("man_pulse", gain_change, 1);
        check("man_stable_lo", stable, 0);
        av0 = av_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_data = (i % 2 == 0) ? 12'd50 : 12'd4050;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        idle(15);
        check("man_hold_stable", stable, 1);
        gc0 = gc_cnt;
        send_window(50, 4050, -1);
        send_window(50, 4050, -1);
        idle(2);
        $display("[TB] HOLD p2p=4000 x2 -> gain=%0d stable=%0d", gain_code, stable);
        check("hold_gain", gain_code, 3);
        check("hold_gc_pulses", gc_cnt - gc0, 0);
        check("hold_amp_pulses", av_cnt - av0, 0);

        manual_gain = 2'd1;
        @(negedge clk);
        $display("[TB] manual_gain=1 -> gain=%0d", gain_code);
        check("man_regain", gain_code, 1);
        idle(25);
        manual_en = 1'b0;
        @(negedge clk);
        $display("[TB] manual_en fall -> stable=%0d", stable);
        check("man_fall_stable", stable, 0);
        gc0 = gc_cnt; av0 = av_cnt;
        send_window(1000, 3000, -1);
        idle(2);
        $display("[TB] post-manual window -> amp=%0d stable=%0d gain=%0d", amp, stable, gain_code);
        check("auto_amp", amp, 2000);
        check("auto_amp_pulses", av_cnt - av0, 1);
        check("auto_stable", stable, 1);
        check("auto_gc_pulses", gc_cnt - gc0, 0);

        // Reset mid-SETTLE takes priority
        manual_en = 1'b1; manual_gain = 2'd2;
        @(negedge clk);
        check("pre_rst_gain", gain_code, 2);
        idle(5);
        rst_n = 1'b0; manual_en = 1'b0;
        @(negedge clk);
        $display("[TB] reset mid-settle -> gain=%0d amp=%0d stable=%0d", gain_code, amp, stable);
        check("rst_gain", gain_code, 0);
        check("rst_change", gain_change, 0);
        check("rst_stable", stable, 0);
        check("rst_over", over_range, 0);
        check("rst_amp", amp, 0);
        check("rst_amp_valid", amp_valid, 0);
        rst_n = 1'b1;
        idle(3);

        // STEPS=3 instance clamps manual request to the top code
        manual_en2 = 1'b1; manual_gain2 = 2'd3;
        @(negedge clk);
        $display("[TB] steps3 manual_gain=3 -> gain=%0d change=%0d", gain_code2, gain_change2);
        check("s3_clamp_gain", gain_code2, 2);
        check("s3_pulse", gain_change2, 1);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
